vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port 16K video RAM between two requesters:
  - the ULA video fetch engine (va/vramdata path);
  - Z80 accesses to 0x4000–0x7FFF, already decoded upstream to a 14-bit offset.
- Sequences fixed-length SRAM access slots and gives video priority, with a bounded CPU starvation guarantee.
- Posts CPU writes into a 1-deep buffer so writes acknowledge without waiting for a slot.
- Sits between ula_radas, the CPU bus glue and the external/BRAM video memory.

Parameters:
- ACC_CYCLES, 2, clock cycles per SRAM access slot (legal range 1..7).
- MAX_VID_RUN, 4, consecutive video slots granted while CPU work is pending before one CPU slot is forced (legal range 1..15).

Ports:
- clk14  in  1   system clock; every flop is clocked on its rising edge.
- rst  in  1   reset, synchronous and active-high.
- vid_req  in  1   single-cycle video fetch request.
- vid_addr  in  14  video fetch address, sampled when vid_req=1.
- vid_data  out  8   fetched byte, valid when vid_valid=1.
- vid_valid  out  1   single-cycle pulse marking vid_data valid.
- vid_overrun  out  1   sticky flag: a video request was lost; cleared only by rst.
- cpu_req  in  1   CPU request level; the requester holds it until cpu_ack.
- cpu_we  in  1   1 = write, 0 = read; stable while cpu_req=1.
- cpu_addr  in  14  CPU address; stable while cpu_req=1.
- cpu_din  in  8   CPU write data.
- cpu_dout  out  8   CPU read data, valid with cpu_ack on a read.
- cpu_ack  out  1   single-cycle acknowledge.
- cpu_wait  out  1   contention indicator: cpu_req=1 and the request is not acknowledged this cycle.
- sram_a  out  14  SRAM address.
- sram_dout  out  8   SRAM write data.
- sram_din  in  8   SRAM read data.
- sram_we_n  out  1   SRAM write enable, active-low.
- sram_oe_n  out  1   SRAM output enable, active-low.

Behaviour:
- State machine: IDLE, VID, CPU_RD, WB (write-buffer drain). A slot counter runs 0..ACC_CYCLES-1 inside VID, CPU_RD and WB.
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; vid_pend, wbuf_full, run counter and vid_overrun are cleared.
  - Outputs: vid_valid=0, cpu_ack=0, sram_we_n=1, sram_oe_n=1, sram_a=0, sram_dout=0, vid_data=0, cpu_dout=0.
  - Any slot in progress is abandoned with no ack and no valid.
- Video capture:
  - vid_req=1 sets vid_pend and latches vid_addr.
  - If vid_req=1 while vid_pend=1 and that pending request has not yet started its slot: the new address overwrites the old one and vid_overrun is set.
- CPU write posting:
  - cpu_req=1, cpu_we=1 and wbuf_full=0 latch cpu_addr/cpu_din into the buffer and set wbuf_full.
  - cpu_ack pulses on the next cycle; cpu_wait=0 in the capture cycle.
  - If the buffer is full, the write waits with cpu_wait=1.
  - The requester must drop cpu_req in the cycle after cpu_ack; a write is never captured twice.
- CPU read:
  - A read is eligible only when wbuf_full=0, which preserves read-after-write order.
  - cpu_wait=1 from the first cpu_req cycle until the cpu_ack cycle.
- Arbitration:
  - Evaluated in IDLE and in the last cycle of every slot, so slots can run back-to-back.
  - Priority order: vid_pend, then WB, then CPU_RD.
  - Exception: if the run counter equals MAX_VID_RUN and CPU work is eligible, CPU work wins that one decision.
  - The run counter increments on each VID grant while CPU work is eligible. It clears on any CPU grant, and clears whenever no CPU work is eligible.
  - Nothing eligible: go to IDLE.
- Slot signals:
  - sram_a is driven from the winner's address for the whole slot.
  - VID and CPU_RD: sram_oe_n=0 for the whole slot; sram_din is sampled on the last slot cycle.
  - WB: sram_dout = buffered data.
    - ACC_CYCLES>1: sram_we_n=0 on every slot cycle except the last.
    - ACC_CYCLES=1: sram_we_n=0 on the single cycle.
  - vid_pend is cleared when the VID slot starts. A new vid_req may arrive during that slot and is not an overrun.
- Completion, one cycle after the last slot cycle:
  - VID: vid_valid=1 and vid_data = sampled byte.
  - CPU_RD: cpu_ack=1 and cpu_dout = sampled byte.
  - WB: wbuf_full clears (no ack; the write was acked at capture).
  - vid_data and cpu_dout hold their values until the next completion of the same kind.
- Latency:
  - Video with the arbiter idle: vid_req at cycle T gives vid_valid at T+ACC_CYCLES+1.
  - Video worst case: one extra slot in progress, plus one forced CPU slot, i.e. +2·ACC_CYCLES.
- Simultaneous events:
  - vid_req and a pending CPU read in the same cycle: video is granted first.
  - The write-capture cycle may coincide with a WB slot ending: the clear happens before the set, so the new write is captured.

Test Plan:
- Reset mid VID slot with ACC_CYCLES=2 (rst on slot cycle 1) → no vid_valid afterward; sram_oe_n=1 and state IDLE the cycle after rst.
- Idle arbiter, vid_req at T with vid_addr=0x1800, mem[0x1800]=0xA5 → sram_oe_n=0 at T+1..T+2; vid_valid=1 with vid_data=0xA5 at T+3.
- CPU write cpu_addr=0x0000, cpu_din=0x5A, buffer empty → cpu_ack next cycle, cpu_wait=0; next slot has sram_we_n=0 one cycle; a later CPU read of 0x0000 returns 0x5A.
- cpu_req read held while vid_req pulses every 2 cycles (MAX_VID_RUN=4) → exactly 4 VID slots, then a CPU_RD slot, then cpu_ack; cpu_wait=1 throughout.
- Two vid_req pulses during an ongoing CPU slot → vid_overrun=1; only the second address is fetched; one vid_valid.
- ACC_CYCLES=1, with a pending write and a pending read → WB slot then CPU_RD slot back-to-back, no idle cycle between them; the read waits for the buffer drain.

Source files
------------

// File: rtl/vram_arbiter.sv
// ============================================================================
// vram_arbiter: slot sequencer sharing the 16K VRAM between ULA video and Z80
// Rev 1.0
// ============================================================================
`default_nettype none

module vram_arbiter #(
  parameter int ACC_CYCLES  = 2,
  parameter int MAX_VID_RUN = 4
) (
  input  logic        clk14,
  input  logic        rst,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  output logic        vid_overrun,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_wait,
  output logic [13:0] sram_a,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  typedef enum logic [1:0] {IDLE = 2'd0, VID = 2'd1, CPU_RD = 2'd2, WB = 2'd3} state_t;

  localparam logic [2:0] SLOT_LAST = 3'(ACC_CYCLES - 1);
  localparam logic [2:0] WE_LAST   = 3'(ACC_CYCLES - 2);
  localparam logic [3:0] RUN_MAX   = 4'(MAX_VID_RUN);

  state_t      state, state_nxt, grant;
  logic [2:0]  slot_cnt;
  logic [3:0]  run_cnt;
  logic        vid_pend;
  logic [13:0] vid_addr_q;
  logic        wbuf_full;
  logic [13:0] wbuf_addr;
  logic [7:0]  wbuf_data;

  logic        slot_last, decide, wb_done, wbuf_busy;
  logic        vid_elig, wb_elig, rd_elig, cpu_elig, wr_cap;
  logic [13:0] vid_sel_addr;

  assign slot_last = (state != IDLE) && (slot_cnt == SLOT_LAST);
  assign decide    = (state == IDLE) || slot_last;
  assign wb_done   = (state == WB) && slot_last;
  // A buffer draining on this cycle counts as empty: clear wins over set.
  assign wbuf_busy = wbuf_full && !wb_done;

  assign vid_elig  = vid_pend || vid_req;
  assign wb_elig   = wbuf_busy;
  assign rd_elig   = cpu_req && !cpu_we && !wbuf_busy && (state != CPU_RD) && !cpu_ack;
  assign cpu_elig  = wb_elig || rd_elig;
  assign wr_cap    = cpu_req && cpu_we && !wbuf_busy && !cpu_ack;
  assign cpu_wait  = cpu_req && !cpu_ack && !wr_cap;

  assign vid_sel_addr = vid_req ? vid_addr : vid_addr_q;

  always_comb begin
    grant     = IDLE;
    state_nxt = state;
    if (cpu_elig && (run_cnt >= RUN_MAX)) grant = wb_elig ? WB : CPU_RD;
    else if (vid_elig)                    grant = VID;
    else if (wb_elig)                     grant = WB;
    else if (rd_elig)                     grant = CPU_RD;
    if (decide) state_nxt = grant;
  end

  always_ff @(posedge clk14) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk14) begin
    if (rst) begin
      slot_cnt    <= 3'd0;
      run_cnt     <= 4'd0;
      vid_pend    <= 1'b0;
      vid_addr_q  <= 14'd0;
      vid_overrun <= 1'b0;
      wbuf_full   <= 1'b0;
      wbuf_addr   <= 14'd0;
      wbuf_data   <= 8'd0;
      vid_valid   <= 1'b0;
      vid_data    <= 8'd0;
      cpu_ack     <= 1'b0;
      cpu_dout    <= 8'd0;
      sram_a      <= 14'd0;
      sram_dout   <= 8'd0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      slot_cnt  <= decide ? 3'd0 : slot_cnt + 3'd1;
      vid_valid <= 1'b0;
      cpu_ack   <= wr_cap;

      if (slot_last && (state == VID)) begin
        vid_valid <= 1'b1;
        vid_data  <= sram_din;
      end
      if (slot_last && (state == CPU_RD)) begin
        cpu_ack  <= 1'b1;
        cpu_dout <= sram_din;
      end

      // A second request before the first reached its slot replaces it.
      if (vid_req && vid_pend) vid_overrun <= 1'b1;
      if (decide && (grant == VID)) begin
        vid_pend <= 1'b0;
      end else if (vid_req) begin
        vid_pend   <= 1'b1;
        vid_addr_q <= vid_addr;
      end

      if (wb_done) wbuf_full <= 1'b0;
      if (wr_cap) begin
        wbuf_full <= 1'b1;
        wbuf_addr <= cpu_addr;
        wbuf_data <= cpu_din;
      end

      if (!cpu_elig) begin
        run_cnt <= 4'd0;
      end else if (decide) begin
        if (grant == VID) run_cnt <= run_cnt + 4'd1;
        else              run_cnt <= 4'd0;
      end

      if (decide) begin
        sram_we_n <= 1'b1;
        sram_oe_n <= 1'b1;
        case (grant)
          VID: begin
            sram_a    <= vid_sel_addr;
            sram_oe_n <= 1'b0;
          end
          CPU_RD: begin
            sram_a    <= cpu_addr;
            sram_oe_n <= 1'b0;
          end
          WB: begin
            sram_a    <= wbuf_addr;
            sram_dout <= wbuf_data;
            sram_we_n <= 1'b0;
          end
          default: ;
        endcase
      end else if ((state == WB) && (slot_cnt == WE_LAST)) begin
        // Release write enable one cycle early so data/address hold past it.
        sram_we_n <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// tb_vram_arbiter: scoreboard bench for vram_arbiter (ACC_CYCLES=2 and =1)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

  logic clk14 = 1'b0;
  always #5 clk14 = ~clk14;

  logic        rst;
  logic        vid_req, vid_valid, vid_overrun;
  logic [13:0] vid_addr;
  logic [7:0]  vid_data;
  logic        cpu_req, cpu_we, cpu_ack, cpu_wait;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic [13:0] sram_a;
  logic [7:0]  sram_dout, sram_din;
  logic        sram_we_n, sram_oe_n;

  logic        vid_req_b, vid_valid_b, vid_overrun_b;
  logic [13:0] vid_addr_b;
  logic [7:0]  vid_data_b;
  logic        cpu_req_b, cpu_we_b, cpu_ack_b, cpu_wait_b;
  logic [13:0] cpu_addr_b;
  logic [7:0]  cpu_din_b, cpu_dout_b;
  logic [13:0] sram_a_b;
  logic [7:0]  sram_dout_b, sram_din_b;
  logic        sram_we_n_b, sram_oe_n_b;

  vram_arbiter #(.ACC_CYCLES(2), .MAX_VID_RUN(4)) u_dut (
    .clk14(clk14), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_overrun(vid_overrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .sram_a(sram_a), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  vram_arbiter #(.ACC_CYCLES(1), .MAX_VID_RUN(4)) u_dut_b (
    .clk14(clk14), .rst(rst),
    .vid_req(vid_req_b), .vid_addr(vid_addr_b), .vid_data(vid_data_b),
    .vid_valid(vid_valid_b), .vid_overrun(vid_overrun_b),
    .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_din(cpu_din_b),
    .cpu_dout(cpu_dout_b), .cpu_ack(cpu_ack_b), .cpu_wait(cpu_wait_b),
    .sram_a(sram_a_b), .sram_dout(sram_dout_b), .sram_din(sram_din_b),
    .sram_we_n(sram_we_n_b), .sram_oe_n(sram_oe_n_b)
  );

  // Behavioural SRAMs behind each arbiter, plus the reference image.
  logic [7:0] mem     [0:16383];
  logic [7:0] mem_b   [0:16383];
  logic [7:0] ref_mem [0:16383];

  assign sram_din   = mem[sram_a];
  assign sram_din_b = mem_b[sram_a_b];
  always @(posedge clk14) if (!sram_we_n)   mem[sram_a]     <= sram_dout;
  always @(posedge clk14) if (!sram_we_n_b) mem_b[sram_a_b] <= sram_dout_b;

  logic [7:0] vq[$];
  logic [7:0] cq[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk14);
    #1;
  endtask

  task automatic vid_pulse(input logic [13:0] a);
    tick();
    vid_req  = 1'b1;
    vid_addr = a;
    vq.push_back(ref_mem[a]);
    tick();
    vid_req = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input logic [13:0] a, input logic [7:0] d);
    int n;
    tick();
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = a;
    cpu_din  = d;
    if (we) ref_mem[a] = d;
    else    cq.push_back(ref_mem[a]);
    n = 0;
    @(negedge clk14);
    while (!cpu_ack && n < 100) begin
      tick();
      @(negedge clk14);
      n++;
    end
    if (!cpu_ack) chk("cpu_ack_timeout", 32'(n), 32'd0);
    tick();
    cpu_req = 1'b0;
  endtask

  // Scoreboard monitor: every output pulse is matched against queued expectations.
  always @(negedge clk14) begin
    if (vid_valid) begin
      chk("vid_q_nonempty", 32'(vq.size() != 0), 32'd1);
      if (vq.size() != 0) chk("vid_data", 32'(vid_data), 32'(vq.pop_front()));
    end
    if (cpu_ack && !cpu_we) begin
      chk("cpu_q_nonempty", 32'(cq.size() != 0), 32'd1);
      if (cq.size() != 0) chk("cpu_dout", 32'(cpu_dout), 32'(cq.pop_front()));
    end
    chk("sram_we_oe_exclusive", 32'(sram_we_n | sram_oe_n), 32'd1);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks", passes, checks);
    $fatal(1);
  end

  initial begin
    int nvid;
    bit acked;
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = 8'($urandom);
      mem_b[i]   = mem[i];
      ref_mem[i] = mem[i];
    end
    mem[14'h1800] = 8'hA5; ref_mem[14'h1800] = 8'hA5;
    rst = 1'b1;
    vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    vid_req_b = 1'b0; vid_addr_b = '0; cpu_req_b = 1'b0; cpu_we_b = 1'b0;
    cpu_addr_b = '0; cpu_din_b = '0;

    tick(); tick();
    @(negedge clk14);
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_we_oe", 32'({sram_we_n, sram_oe_n}), 32'd3);
    chk("rst_sram_a", 32'(sram_a), 32'd0);
    chk("rst_sram_dout", 32'(sram_dout), 32'd0);
    chk("rst_data_regs", 32'({vid_data, cpu_dout}), 32'd0);
    chk("rst_overrun", 32'(vid_overrun), 32'd0);
    tick();
    rst = 1'b0;

    // Idle video fetch latency.
    tick();
    vid_req = 1'b1; vid_addr = 14'h1800; vq.push_back(8'hA5);
    tick(); vid_req = 1'b0;
    @(negedge clk14); chk("idle_vid_oe_t1", 32'(sram_oe_n), 32'd0);
    chk("idle_vid_addr", 32'(sram_a), 32'h1800);
    tick(); @(negedge clk14); chk("idle_vid_oe_t2", 32'(sram_oe_n), 32'd0);
    chk("idle_vid_valid_early", 32'(vid_valid), 32'd0);
    tick(); @(negedge clk14); chk("idle_vid_valid_t3", 32'(vid_valid), 32'd1);
    chk("idle_vid_data", 32'(vid_data), 32'hA5);
    chk("idle_vid_oe_release", 32'(sram_oe_n), 32'd1);

    // Posted write then read-back.
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0000; cpu_din = 8'h5A; ref_mem[0] = 8'h5A;
    @(negedge clk14); chk("wr_capture_wait", 32'(cpu_wait), 32'd0);
    chk("wr_capture_ack", 32'(cpu_ack), 32'd0);
    tick(); @(negedge clk14); chk("wr_ack_next", 32'(cpu_ack), 32'd1);
    tick(); cpu_req = 1'b0;
    @(negedge clk14); chk("wb_we_low", 32'(sram_we_n), 32'd0);
    chk("wb_dout", 32'(sram_dout), 32'h5A);
    tick(); @(negedge clk14); chk("wb_we_high_last", 32'(sram_we_n), 32'd1);
    cpu_op(1'b0, 14'h0000, 8'h00);

    // Randomised concurrent traffic; CPU in 0x0000-0x0FFF, video above.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          cpu_op(1'($urandom_range(0, 1)), 14'($urandom_range(0, 4095)), 8'($urandom));
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          vid_pulse(14'($urandom_range(4096, 16383)));
          repeat ($urandom_range(6, 12)) tick();
        end
      end
    join
    repeat (20) tick();
    chk("rand_vid_drained", 32'(vq.size()), 32'd0);
    chk("rand_cpu_drained", 32'(cq.size()), 32'd0);
    chk("rand_no_overrun", 32'(vid_overrun), 32'd0);

    // Bounded starvation: read held while video requests every 2 cycles.
    tick();
    vid_req = 1'b1; vid_addr = 14'h3000; vq.push_back(ref_mem[14'h3000]);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0040; cq.push_back(ref_mem[14'h0040]);
    nvid = 0; acked = 1'b0;
    for (int c = 0; c < 40 && !acked; c++) begin
      if (c > 0) begin
        tick();
        vid_req = (c % 2 == 0) && (c <= 8);
        if (vid_req) begin
          vid_addr = 14'(14'h3000 + c);
          vq.push_back(ref_mem[vid_addr]);
        end
      end
      @(negedge clk14);
      if (cpu_ack) begin
        acked = 1'b1;
        chk("starve_vid_slots", 32'(nvid), 32'd4);
      end else begin
        chk("starve_wait", 32'(cpu_wait), 32'd1);
      end
      if (vid_valid) nvid++;
    end
    chk("starve_acked", 32'(acked), 32'd1);
    tick(); cpu_req = 1'b0; vid_req = 1'b0;
    repeat (8) tick();
    chk("starve_vid_drained", 32'(vq.size()), 32'd0);
    chk("starve_no_overrun", 32'(vid_overrun), 32'd0);

    // Two video requests during a CPU slot: only the second is fetched.
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010; cq.push_back(ref_mem[14'h0010]);
    tick(); vid_req = 1'b1; vid_addr = 14'h2100;
    tick(); vid_addr = 14'h2200; vq.push_back(ref_mem[14'h2200]);
    @(negedge clk14); chk("ovr_not_yet", 32'(vid_overrun), 32'd0);
    tick(); vid_req = 1'b0;
    @(negedge clk14); chk("ovr_cpu_ack", 32'(cpu_ack), 32'd1);
    chk("ovr_flag", 32'(vid_overrun), 32'd1);
    tick(); cpu_req = 1'b0;
    nvid = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk14);
      if (vid_valid) nvid++;
      tick();
    end
    chk("ovr_one_valid", 32'(nvid), 32'd1);
    chk("ovr_sticky", 32'(vid_overrun), 32'd1);

    // ACC_CYCLES=1: read waits for the buffer drain, then slots abut.
    tick();
    cpu_req_b = 1'b1; cpu_we_b = 1'b1; cpu_addr_b = 14'h0123; cpu_din_b = 8'h3C;
    @(negedge clk14); chk("b_wr_wait", 32'(cpu_wait_b), 32'd0);
    tick(); vid_req_b = 1'b1; vid_addr_b = 14'h2001;
    @(negedge clk14); chk("b_wr_ack", 32'(cpu_ack_b), 32'd1);
    tick(); cpu_req_b = 1'b0; vid_addr_b = 14'h2002;
    tick(); vid_req_b = 1'b0; cpu_req_b = 1'b1; cpu_we_b = 1'b0; cpu_addr_b = 14'h0123;
    @(negedge clk14); chk("b_rd_wait_c3", 32'(cpu_wait_b), 32'd1);
    chk("b_vid1_valid", 32'(vid_valid_b), 32'd1);
    chk("b_vid1_data", 32'(vid_data_b), 32'(ref_mem[14'h2001]));
    tick(); @(negedge clk14); chk("b_wb_we", 32'(sram_we_n_b), 32'd0);
    chk("b_rd_wait_c4", 32'(cpu_wait_b), 32'd1);
    chk("b_vid2_data", 32'(vid_data_b), 32'(ref_mem[14'h2002]));
    tick(); @(negedge clk14); chk("b_rd_oe", 32'(sram_oe_n_b), 32'd0);
    chk("b_rd_addr", 32'(sram_a_b), 32'h0123);
    tick(); @(negedge clk14); chk("b_rd_ack", 32'(cpu_ack_b), 32'd1);
    chk("b_rd_data", 32'(cpu_dout_b), 32'h3C);
    tick(); cpu_req_b = 1'b0;

    // Reset during the last cycle of a video slot abandons it.
    tick(); vid_req = 1'b1; vid_addr = 14'h2300;
    tick(); vid_req = 1'b0;
    tick(); rst = 1'b1;
    @(negedge clk14); chk("rstmid_oe_in_slot", 32'(sram_oe_n), 32'd0);
    tick(); rst = 1'b0;
    @(negedge clk14); chk("rstmid_oe", 32'(sram_oe_n), 32'd1);
    chk("rstmid_valid", 32'(vid_valid), 32'd0);
    chk("rstmid_overrun_clr", 32'(vid_overrun), 32'd0);
    nvid = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk14);
      if (vid_valid) nvid++;
    end
    chk("rstmid_no_valid", 32'(nvid), 32'd0);
    chk("final_vid_drained", 32'(vq.size()), 32'd0);
    chk("final_cpu_drained", 32'(cq.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
